// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode instruction queue handshake bundle
interface fetch_queue_if #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int DEPTH            = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ARQ-1:0]              in_instr;
  logic [MEMORY_ADDR_SIZE-1:0] in_pc;
  logic                        in_valid;
  logic                        pc_en;
  logic                        flush;
  logic [ARQ-1:0]              out_instr;
  logic [MEMORY_ADDR_SIZE-1:0] out_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [CW-1:0]               count;

  // fetch/decode side: drives instructions in and acceptance out
  modport master (
    output in_instr, in_pc, in_valid, flush, out_ready,
    input  pc_en, out_instr, out_pc, out_valid, count
  );

  // queue side
  modport slave (
    input  in_instr, in_pc, in_valid, flush, out_ready,
    output pc_en, out_instr, out_pc, out_valid, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of {instr, pc} between fetch and decode
module fetch_queue #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int DEPTH            = 4
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ARQ-1:0]              instr_mem [DEPTH];
  logic [MEMORY_ADDR_SIZE-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PW:0]                 cnt;
  logic                        wr_en;
  logic                        rd_en;

  // Full blocks fetch regardless of decode readiness: no bypass path when full.
  assign bus.pc_en     = (cnt < FULL_CNT);
  assign bus.out_valid = (cnt != '0);
  assign bus.count     = cnt;

  // Flush kills both same-cycle events so nothing leaks across a taken branch.
  assign wr_en = bus.in_valid & bus.pc_en & ~bus.flush;
  assign rd_en = bus.out_valid & bus.out_ready & ~bus.flush;

  // Head entry is shown combinationally; zeros when nothing is held.
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : '0;
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr]    : '0;

  // Storage is not cleared; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ARQ, default 16, instruction width in bits.
REQ-002 Parameter MEMORY_ADDR_SIZE, default 13, instruction address width in bits.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_instr  input  ARQ  instruction from fetch stage.
REQ-007 in_pc  input  MEMORY_ADDR_SIZE  address in_instr was fetched from.
REQ-008 in_valid  input  1  in_instr/in_pc valid this cycle.
REQ-009 pc_en  output  1  queue can accept; drives fetch PC-register enable.
REQ-010 flush  input  1  branch taken; discard all queued entries.
REQ-011 out_instr  output  ARQ  head instruction to decode stage.
REQ-012 out_pc  output  MEMORY_ADDR_SIZE  address of head instruction.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  decode accepts head this cycle (low = decode stall).
REQ-015 count  output  log2(DEPTH)+1  entries currently held.

Function
REQ-016 Storage: DEPTH entries of {instr, pc}; write pointer, read pointer, each log2(DEPTH) bits, wrap DEPTH-1 -> 0 by natural overflow.
REQ-017 pc_en SHALL be combinational: 1 when count < DEPTH, else 0; independent of out_ready (no full-queue bypass).
REQ-018 Write event = in_valid & pc_en & ~flush: store {in_instr, in_pc} at write pointer, increment write pointer.
REQ-019 Read event = out_valid & out_ready & ~flush: increment read pointer.
REQ-020 count next = count + write - read; simultaneous write and read leaves count unchanged.
REQ-021 out_valid SHALL be combinational: 1 when count != 0.
REQ-022 out_instr/out_pc SHALL show entry at read pointer combinationally when out_valid=1; all-zero when out_valid=0.
REQ-023 Latency: entry written at edge N visible on outputs after edge N (zero extra cycles); no write-to-read bypass when empty.
REQ-024 Order: strict FIFO; entries leave in write order.
REQ-025 Full (count=DEPTH): pc_en=0; in_valid ignored, no storage or pointer change even if read occurs same cycle.
REQ-026 Empty (count=0): out_valid=0; out_ready ignored, read pointer unchanged.
REQ-027 flush=1 at an edge: pointers and count SHALL become 0; same-cycle write and read both dropped; flush has priority over all events.
REQ-028 flush held multiple cycles: queue stays empty; pc_en=1 from the cycle after first flush edge.
REQ-029 Storage array contents need not be cleared by flush or reset; only pointers/count define validity.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force write pointer, read pointer, count to 0.
REQ-031 During and after reset: out_valid=0, out_instr=0, out_pc=0, count=0, pc_en=1.
REQ-032 Reset asserted mid-operation discards all entries; first write after release lands in entry 0.
REQ-033 Reset release synchronous to clk; no event on the edge coinciding with release if rst still low.

Verification
REQ-034 Reset, then in_valid=1, in_instr=16'hA001..16'hA004, in_pc=0..3, out_ready=0 for 4 cycles -> count=4, pc_en=0, out_instr=16'hA001, out_pc=0.
REQ-035 From full, in_valid=1 in_instr=16'hBEEF, out_ready=1 one cycle -> count=3, pc_en=1, out_instr=16'hA002, 16'hBEEF never appears.
REQ-036 Steady stream in_valid=1, out_ready=1, 10 instructions -> count constant, outputs in order, write/read pointers wrap 3->0 with no loss.
REQ-037 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=0, pc_en=1; then write 16'hC000 pc=13'h100 -> out_instr=16'hC000, out_pc=13'h100.
REQ-038 count=2, rst driven low between clock edges -> count=0, out_valid=0 before next edge; after release first write appears at head.
REQ-039 Empty queue, out_ready=1, in_valid=0 for 3 cycles -> count stays 0, out_valid=0, no pointer movement.
